// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Pixel/line counters with
//                registered sync, blank and frame-tick outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int         c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int         c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_draw_x;
  logic [9:0] r_draw_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_frame_tick;
  logic [7:0] r_frame_count;

  logic [9:0] w_next_x;
  logic [9:0] w_next_y;
  logic       w_x_wrap;
  logic       w_next_tick;

  // Outputs are decoded from the next counter values so they land on the
  // same edge as the coordinates they describe.
  always_comb begin
    w_x_wrap    = (r_draw_x == c_H_LAST);
    w_next_x    = w_x_wrap ? 10'd0 : r_draw_x + 10'd1;
    w_next_y    = r_draw_y;
    if (w_x_wrap) begin
      w_next_y  = (r_draw_y == c_V_LAST) ? 10'd0 : r_draw_y + 10'd1;
    end
    w_next_tick = (w_next_x == 10'd0) && (w_next_y == c_V_VIS);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_draw_x      <= 10'd0;
      r_draw_y      <= 10'd0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_draw_x      <= w_next_x;
      r_draw_y      <= w_next_y;
      r_blank       <= (w_next_x < c_H_VIS) && (w_next_y < c_V_VIS);
      r_hs          <= !((w_next_x >= c_HS_START) && (w_next_x < c_HS_END));
      r_vs          <= !((w_next_y >= c_VS_START) && (w_next_y < c_VS_END));
      r_frame_tick  <= w_next_tick;
      if (w_next_tick) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign frame_tick  = r_frame_tick;
  assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen against an arithmetic
//                raster model, using a reduced timing geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] DrawX, DrawY;
  logic       hs, vs, blank, frame_tick;
  logic [7:0] frame_count;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;
  int cyc      = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .hs         (hs),
    .vs         (vs),
    .blank      (blank),
    .frame_tick (frame_tick),
    .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d cyc=%0d)", tag, obs, exp, t, cyc);
    end
  endtask

  // t counts free-running edges since the last reset edge; everything the
  // raster should show follows from t alone.
  task automatic check_model();
    int x, y, cnt;
    x   = t % HT;
    y   = (t / HT) % VT;
    cnt = (t >= VV * HT) ? (((t - VV * HT) / FT) + 1) % 256 : 0;
    chk("DrawX", 32'(DrawX), 32'(x));
    chk("DrawY", 32'(DrawY), 32'(y));
    chk("blank", 32'(blank), 32'((t != 0) && (x < HV) && (y < VV)));
    chk("hs", 32'(hs), 32'(!((x >= HV + HF) && (x < HV + HF + HS))));
    chk("vs", 32'(vs), 32'(!((y >= VV + VF) && (y < VV + VF + VS))));
    chk("frame_tick", 32'(frame_tick), 32'((x == 0) && (y == VV)));
    chk("frame_count", 32'(frame_count), 32'(cnt));
  endtask

  task automatic step();
    @(posedge vga_clk);
    if (reset) t = 0;
    else       t++;
    cyc++;
    #1;
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_tick(input int budget, output int at_cyc);
    bit found;
    found  = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (frame_tick === 1'b1) begin
        found  = 1'b1;
        at_cyc = cyc;
      end
    end
    chk("tick_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    int hs_low, vs_low, c0, c1, c2;
    bit found;

    // Scenario 1: reset held three edges, then release.
    reset = 1'b1;
    @(posedge vga_clk);
    #1;
    repeat (3) step();
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_hs", 32'(hs), 32'd1);
    reset = 1'b0;
    step();
    chk("first_x", 32'(DrawX), 32'd1);
    chk("first_blank", 32'(blank), 32'd1);

    // Scenario 2: one full line, count hs-low cycles.
    hs_low = 0;
    for (int i = 0; i < HT; i++) begin
      step();
      if (hs === 1'b0) hs_low++;
    end
    chk("hs_low_cycles", 32'(hs_low), 32'(HS));
    chk("line_wrap_y", 32'(DrawY), 32'd1);

    // Scenario 3: one full frame, count vs-low cycles.
    vs_low = 0;
    for (int i = 0; i < FT; i++) begin
      step();
      if (vs === 1'b0) vs_low++;
    end
    chk("vs_low_cycles", 32'(vs_low), 32'(VS * HT));

    // Scenario 4: successive ticks one frame apart.
    run_until_tick(2 * FT, c0);
    chk("tick_y", 32'(DrawY), 32'(VV));
    run_until_tick(2 * FT, c1);
    run_until_tick(2 * FT, c2);
    chk("tick_period_a", 32'(c1 - c0), 32'(FT));
    chk("tick_period_b", 32'(c2 - c1), 32'(FT));

    // Scenario 5: frame_count wrap 255 -> 0.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      run_until_tick(2 * FT, c0);
      if (frame_count == 8'd255) found = 1'b1;
    end
    chk("reach_255", 32'(found), 32'd1);
    run_until_tick(2 * FT, c0);
    chk("count_wrap", 32'(frame_count), 32'd0);

    // Scenario 6: reset inside both sync pulses.
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      step();
      if (DrawX == 10'(HV + HF + 1) && DrawY == 10'(VV + VF)) found = 1'b1;
    end
    chk("reach_sync_pos", 32'(found), 32'd1);
    chk("pre_rst_hs", 32'(hs), 32'd0);
    chk("pre_rst_vs", 32'(vs), 32'd0);
    reset = 1'b1;
    step();
    chk("mid_rst_x", 32'(DrawX), 32'd0);
    chk("mid_rst_cnt", 32'(frame_count), 32'd0);
    reset = 1'b0;

    // Randomized runs with random mid-frame reset pulses.
    for (int k = 0; k < 20; k++) begin
      run($urandom_range(1, 2 * FT));
      reset = 1'b1;
      run($urandom_range(1, 3));
      reset = 1'b0;
    end
    run(FT + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
